// File: rtl/vga_timing_pkg.sv
// Shared display-timing definitions: a timing record, the standard presets
// and helpers that derive the total line/frame lengths from a record.
package vga_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hsync_pol;
    bit vsync_pol;
  } timing_t;

  // 1024x768 @ 70 Hz, 75 MHz pixel clock, both syncs active low.
  localparam timing_t XGA_1024x768_70 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 144,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    hsync_pol: 1'b0, vsync_pol: 1'b0
  };

  // 640x480 @ 60 Hz, 25 MHz pixel clock, both syncs active low.
  localparam timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hsync_pol: 1'b0, vsync_pol: 1'b0
  };

  function automatic int h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register used to slide the sync outputs later so they
// line up with the pixel pipeline. DEPTH=0 is a straight wire.
module vga_sync_delay #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rstn;
    assign unused_clk_rstn = clk ^ rstn;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage to RESET_VAL.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_display_timing.sv
// Free-running display timing generator. Produces the pixel position, the
// visible-area flag, line/frame markers and delayed, polarity-adjusted syncs.
// The outputs form a continuous per-clock stream with no handshake: every
// cycle out of reset presents a new, mutually coherent (row, column) sample.
module vga_display_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = XGA_1024x768_70.h_active,
  parameter int H_FP       = XGA_1024x768_70.h_fp,
  parameter int H_SYNC     = XGA_1024x768_70.h_sync,
  parameter int H_BP       = XGA_1024x768_70.h_bp,
  parameter int V_ACTIVE   = XGA_1024x768_70.v_active,
  parameter int V_FP       = XGA_1024x768_70.v_fp,
  parameter int V_SYNC     = XGA_1024x768_70.v_sync,
  parameter int V_BP       = XGA_1024x768_70.v_bp,
  parameter bit HSYNC_POL  = XGA_1024x768_70.hsync_pol,
  parameter bit VSYNC_POL  = XGA_1024x768_70.vsync_pol,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        horiz_sync,
  output logic        vert_sync
);

  localparam timing_t CFG = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
    hsync_pol: HSYNC_POL, vsync_pol: VSYNC_POL
  };
  localparam int H_TOT = h_total(CFG);
  localparam int V_TOT = v_total(CFG);

  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [1:0]  SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL};

  if (H_TOT > 4096) begin : g_h_total_check
    $error("vga_display_timing: H_TOTAL %0d exceeds 4096", H_TOT);
  end
  if (V_TOT > 4096) begin : g_v_total_check
    $error("vga_display_timing: V_TOTAL %0d exceeds 4096", V_TOT);
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_delay_check
    $error("vga_display_timing: SYNC_DELAY %0d outside 0..4", SYNC_DELAY);
  end

  // Counters park on the last position during reset so the first edge
  // afterwards lands on (0,0) and produces the frame marker.
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] h_next;
  logic [11:0] v_next;
  logic        hs_next;
  logic        vs_next;
  logic [1:0]  sync_q;

  // Next position and the polarity-adjusted syncs that belong to it.
  always_comb begin
    h_next = h_cnt + 12'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end
    hs_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    vs_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Register counters and every port from the same next position so the
  // flags always describe the row/column shown in that cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt        <= H_LAST;
      v_cnt        <= V_LAST;
      pixel_column <= '0;
      pixel_row    <= '0;
      video_on     <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      sync_q       <= SYNC_IDLE;
    end else begin
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      pixel_column <= h_next;
      pixel_row    <= v_next;
      video_on     <= (h_next < H_VIS) && (v_next < V_VIS);
      line_start   <= (h_next == 12'd0);
      frame_start  <= (h_next == 12'd0) && (v_next == 12'd0);
      sync_q       <= {hs_next, vs_next};
    end
  end

  // sync_q is coincident with the position ports; the delay line adds the
  // pipeline latency of the downstream pixel path.
  vga_sync_delay #(
    .DEPTH     (SYNC_DELAY),
    .WIDTH     (2),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rstn (rstn),
    .din  (sync_q),
    .dout ({horiz_sync, vert_sync})
  );

endmodule

// File: tb/tb_vga_display_timing.sv
// Bench for vga_display_timing: three instances (XGA defaults, a tiny custom
// timing with an active-high hsync and 3-cycle delay, and the 640x480 preset
// with no delay) are checked against hand-computed (cycle, outputs) vectors.
module tb_vga_display_timing;
  import vga_timing_pkg::*;

  localparam logic [1:0] D_XGA = 2'd0;
  localparam logic [1:0] D_SML = 2'd1;
  localparam logic [1:0] D_VGA = 2'd2;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] cyc;
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
  } vec_t;
  localparam int EW = $bits(vec_t);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [15:0] cyc;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  event check_now;

  logic [11:0] x_col, x_row, s_col, s_row, v_col, v_row;
  logic x_von, x_ls, x_fs, x_hs, x_vs;
  logic s_von, s_ls, s_fs, s_hs, s_vs;
  logic v_von, v_ls, v_fs, v_hs, v_vs;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Cycle k = k-th rising edge since reset release; 0 while in reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= '0;
    else       cyc <= cyc + 16'd1;
  end

  // ---------------- DUTs ----------------
  vga_display_timing u_xga (
    .clk(clk), .rstn(rstn), .pixel_column(x_col), .pixel_row(x_row),
    .video_on(x_von), .line_start(x_ls), .frame_start(x_fs),
    .horiz_sync(x_hs), .vert_sync(x_vs)
  );

  // H: 16/2/3/4 -> 25, V: 8/1/2/3 -> 14, hsync active high, delay 3.
  vga_display_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .SYNC_DELAY(3)
  ) u_sml (
    .clk(clk), .rstn(rstn), .pixel_column(s_col), .pixel_row(s_row),
    .video_on(s_von), .line_start(s_ls), .frame_start(s_fs),
    .horiz_sync(s_hs), .vert_sync(s_vs)
  );

  vga_display_timing #(
    .H_ACTIVE(VGA_640x480_60.h_active), .H_FP(VGA_640x480_60.h_fp),
    .H_SYNC(VGA_640x480_60.h_sync), .H_BP(VGA_640x480_60.h_bp),
    .V_ACTIVE(VGA_640x480_60.v_active), .V_FP(VGA_640x480_60.v_fp),
    .V_SYNC(VGA_640x480_60.v_sync), .V_BP(VGA_640x480_60.v_bp),
    .HSYNC_POL(VGA_640x480_60.hsync_pol), .VSYNC_POL(VGA_640x480_60.vsync_pol),
    .SYNC_DELAY(0)
  ) u_vga (
    .clk(clk), .rstn(rstn), .pixel_column(v_col), .pixel_row(v_row),
    .video_on(v_von), .line_start(v_ls), .frame_start(v_fs),
    .horiz_sync(v_hs), .vert_sync(v_vs)
  );

  // ---------------- driver tasks ----------------
  task automatic push_vec(input logic [1:0] d, input int c, input int col, input int row,
                          input logic von, input logic ls, input logic fs,
                          input logic hs, input logic vs);
    vec_t e;
    e.dut = d;
    e.cyc = 16'(c);
    e.col = 12'(col);
    e.row = 12'(row);
    e.von = von;
    e.ls  = ls;
    e.fs  = fs;
    e.hs  = hs;
    e.vs  = vs;
    exp_q.push_back(e);
  endtask

  // Reset values: position 0, flags 0, syncs at their inactive level.
  task automatic push_reset_vecs();
    push_vec(D_XGA, 0, 0, 0, 0, 0, 0, 1, 1);
    push_vec(D_SML, 0, 0, 0, 0, 0, 0, 0, 1);
    push_vec(D_VGA, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // First edge after release: (0,0), visible, both markers, syncs idle.
  task automatic push_first_edge_vecs();
    push_vec(D_XGA, 1, 0, 0, 1, 1, 1, 1, 1);
    push_vec(D_SML, 1, 0, 0, 1, 1, 1, 0, 1);
    push_vec(D_VGA, 1, 0, 0, 1, 1, 1, 1, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d vectors still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic logic [28:0] actual_of(input logic [1:0] d);
    case (d)
      D_XGA:   return {x_col, x_row, x_von, x_ls, x_fs, x_hs, x_vs};
      D_SML:   return {s_col, s_row, s_von, s_ls, s_fs, s_hs, s_vs};
      default: return {v_col, v_row, v_von, v_ls, v_fs, v_hs, v_vs};
    endcase
  endfunction

  function automatic string name_of(input logic [1:0] d);
    case (d)
      D_XGA:   return "xga";
      D_SML:   return "small";
      default: return "vga640";
    endcase
  endfunction

  initial begin
    vec_t e;
    logic [28:0] act;
    logic [28:0] req;
    forever begin
      @(negedge clk or check_now);
      while (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e.cyc > cyc) break;
        void'(exp_q.pop_front());
        n_vec++;
        req = {e.col, e.row, e.von, e.ls, e.fs, e.hs, e.vs};
        act = actual_of(e.dut);
        if (e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s_missed: vector for cycle %0d seen at cycle %0d", name_of(e.dut), e.cyc, cyc);
        end else if (act !== req) begin
          n_fail++;
          $display("FAIL %s_cyc%0d: got col=%0d row=%0d von/ls/fs/hs/vs=%b, required col=%0d row=%0d von/ls/fs/hs/vs=%b",
                   name_of(e.dut), e.cyc, act[28:17], act[16:5], act[4:0],
                   req[28:17], req[16:5], req[4:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state while held in reset.
    push_reset_vecs();
    repeat (3) @(negedge clk);
    wait_drain(10);

    // Vectors in cycle order, then release on a falling edge.
    push_first_edge_vecs();
    push_vec(D_XGA, 2, 1, 0, 1, 0, 0, 1, 1);
    push_vec(D_SML, 16, 15, 0, 1, 0, 0, 0, 1);
    push_vec(D_SML, 17, 16, 0, 0, 0, 0, 0, 1);
    push_vec(D_SML, 21, 20, 0, 0, 0, 0, 0, 1);
    push_vec(D_SML, 22, 21, 0, 0, 0, 0, 1, 1);
    push_vec(D_SML, 24, 23, 0, 0, 0, 0, 1, 1);
    push_vec(D_SML, 25, 24, 0, 0, 0, 0, 0, 1);
    push_vec(D_SML, 26, 0, 1, 1, 1, 0, 0, 1);
    push_vec(D_SML, 191, 15, 7, 1, 0, 0, 0, 1);
    push_vec(D_SML, 201, 0, 8, 0, 1, 0, 0, 1);
    push_vec(D_SML, 226, 0, 9, 0, 1, 0, 0, 1);
    push_vec(D_SML, 228, 2, 9, 0, 0, 0, 0, 1);
    push_vec(D_SML, 229, 3, 9, 0, 0, 0, 0, 0);
    push_vec(D_SML, 278, 2, 11, 0, 0, 0, 0, 0);
    push_vec(D_SML, 279, 3, 11, 0, 0, 0, 0, 1);
    push_vec(D_SML, 350, 24, 13, 0, 0, 0, 0, 1);
    push_vec(D_SML, 351, 0, 0, 1, 1, 1, 0, 1);
    push_vec(D_SML, 352, 1, 0, 1, 0, 0, 0, 1);
    push_vec(D_VGA, 640, 639, 0, 1, 0, 0, 1, 1);
    push_vec(D_VGA, 641, 640, 0, 0, 0, 0, 1, 1);
    push_vec(D_VGA, 656, 655, 0, 0, 0, 0, 1, 1);
    push_vec(D_VGA, 657, 656, 0, 0, 0, 0, 0, 1);
    push_vec(D_SML, 701, 0, 0, 1, 1, 1, 0, 1);
    push_vec(D_VGA, 752, 751, 0, 0, 0, 0, 0, 1);
    push_vec(D_VGA, 753, 752, 0, 0, 0, 0, 1, 1);
    push_vec(D_VGA, 800, 799, 0, 0, 0, 0, 1, 1);
    push_vec(D_VGA, 801, 0, 1, 1, 1, 0, 1, 1);
    push_vec(D_XGA, 1024, 1023, 0, 1, 0, 0, 1, 1);
    push_vec(D_XGA, 1025, 1024, 0, 0, 0, 0, 1, 1);
    push_vec(D_XGA, 1050, 1049, 0, 0, 0, 0, 1, 1);
    push_vec(D_XGA, 1051, 1050, 0, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 1186, 1185, 0, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 1187, 1186, 0, 0, 0, 0, 1, 1);
    push_vec(D_XGA, 1328, 1327, 0, 0, 0, 0, 1, 1);
    push_vec(D_XGA, 1329, 0, 1, 1, 1, 0, 1, 1);
    push_vec(D_VGA, 1457, 656, 1, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 2352, 1023, 1, 1, 0, 0, 1, 1);
    push_vec(D_XGA, 2379, 1050, 1, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 2514, 1185, 1, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 2515, 1186, 1, 0, 0, 0, 1, 1);
    push_vec(D_XGA, 2657, 0, 2, 1, 1, 0, 1, 1);
    rstn = 1'b1;
    wait_drain(3000);

    // Asynchronous reset in the middle of a line, away from any clock edge.
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    push_reset_vecs();
    ->check_now;
    wait_drain(5);

    // After release the start-up sequence must repeat exactly.
    repeat (2) @(negedge clk);
    push_first_edge_vecs();
    push_vec(D_XGA, 2, 1, 0, 1, 0, 0, 1, 1);
    push_vec(D_SML, 22, 21, 0, 0, 0, 0, 1, 1);
    push_vec(D_SML, 351, 0, 0, 1, 1, 1, 0, 1);
    push_vec(D_VGA, 657, 656, 0, 0, 0, 0, 0, 1);
    push_vec(D_XGA, 1051, 1050, 0, 0, 0, 0, 0, 1);
    rstn = 1'b1;
    wait_drain(1200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
